// File: rtl/fft_frame_buffer.sv
// Frame buffer and byte-stream sequencer: loads one complex frame, hands it to the core, streams it out.
// Optional FFT_BITREV_OUT_EN: drain samples in bit-reversed index order.
module fft_frame_buffer #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  output logic            core_start,
  input  logic            core_done,
  input  logic [AW-1:0]   core_addr,
  input  logic            core_we,
  input  logic [2*W-1:0]  core_wdata,
  output logic [2*W-1:0]  core_rdata,
  output logic            out_valid,
  output logic [7:0]      out_data,
  input  logic            out_ready,
  output logic [1:0]      state
);

  localparam int unsigned BPC = W / 8;
  localparam int unsigned SB  = 2 * BPC;      // bytes per sample
  localparam int unsigned LB  = $clog2(SB);
  localparam int unsigned TB  = N * SB;       // bytes per frame
  localparam int unsigned BCW = $clog2(TB);

  typedef enum logic [1:0] {
    StLoad    = 2'd0,
    StCompute = 2'd1,
    StDrain   = 2'd2
  } state_e;

  state_e          state_q;
  logic [BCW-1:0]  bc;
  logic [2*W-1:0]  mem [N];

  logic [AW-1:0]   k;
  logic [AW-1:0]   rk;
  logic [LB-1:0]   sel;
  logic            bc_last;

  assign k       = bc[BCW-1:LB];
  // Byte slot counted from the word MSB: re MSB first, then im.
  assign sel     = LB'(SB - 1) - bc[LB-1:0];
  assign bc_last = (bc == BCW'(TB - 1));

`ifdef FFT_BITREV_OUT_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int unsigned i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction
  assign rk = bitrev(k);
`else
  assign rk = k;
`endif

  assign state      = state_q;
  assign in_ready   = (state_q == StLoad) & ~clr;
  assign out_valid  = (state_q == StDrain) & ~clr;
  assign core_rdata = mem[core_addr];
  assign out_data   = mem[rk][{sel, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StLoad;
      bc         <= '0;
      core_start <= 1'b0;
      for (int unsigned i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      core_start <= 1'b0;
      if (clr) begin
        state_q <= StLoad;
        bc      <= '0;
      end else begin
        case (state_q)
          StLoad: begin
            if (in_valid) begin
              mem[k][{sel, 3'b000} +: 8] <= in_data;
              if (bc_last) begin
                bc         <= '0;
                state_q    <= StCompute;
                core_start <= 1'b1;
              end else begin
                bc <= bc + 1'b1;
              end
            end
          end
          StCompute: begin
            if (core_we) mem[core_addr] <= core_wdata;
            if (core_done) state_q <= StDrain;
          end
          StDrain: begin
            if (out_ready) begin
              if (bc_last) begin
                bc      <= '0;
                state_q <= StLoad;
              end else begin
                bc <= bc + 1'b1;
              end
            end
          end
          default: begin
            state_q <= StLoad;
            bc      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Self-checking bench for fft_frame_buffer: directed table checks plus randomized frames vs a byte-array model.
module tb_fft_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        core_done = 1'b0;
  logic        core_we = 1'b0;
  logic [2:0]  core_addr = 3'd0;
  logic [15:0] core_wdata = 16'h0;
  logic        out_ready = 1'b0;
  logic        in_ready, core_start, out_valid;
  logic [15:0] core_rdata;
  logic [7:0]  out_data;
  logic [1:0]  state;

  logic        in_valid16 = 1'b0;
  logic [7:0]  in_data16 = 8'h00;
  logic [1:0]  core_addr16 = 2'd0;
  logic        in_ready16, core_start16, out_valid16;
  logic [31:0] core_rdata16;
  logic [7:0]  out_data16;
  logic [1:0]  state16;

  fft_frame_buffer #(.N(8), .W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .core_start(core_start), .core_done(core_done),
    .core_addr(core_addr), .core_we(core_we), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .state(state)
  );

  fft_frame_buffer #(.N(4), .W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .in_valid(in_valid16), .in_data(in_data16),
    .in_ready(in_ready16), .core_start(core_start16), .core_done(1'b0),
    .core_addr(core_addr16), .core_we(1'b0), .core_wdata(32'h0),
    .core_rdata(core_rdata16), .out_valid(out_valid16), .out_data(out_data16),
    .out_ready(1'b0), .state(state16)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [8];

  // Model: frame as a flat byte array, sample k = {fb[2k] (re), fb[2k+1] (im)}.
  logic [7:0] fb [16];
  logic [7:0] stim [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev3(input int k);
`ifdef FFT_BITREV_OUT_EN
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4);
`else
    return k;
`endif
  endfunction

  function automatic logic [7:0] exp_byte(input int p);
    return fb[2 * rev3(p / 2) + (p % 2)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int gaps);
    int acc = 0;
    int cyc = 0;
    while (acc < 16 && cyc < 200) begin
      in_valid = (gaps == 0) || ($urandom_range(0, 2) != 0);
      in_data  = in_valid ? stim[acc] : 8'($urandom);
      #1;
      check("load_in_ready", {31'd0, in_ready}, 1);
      if (in_valid) begin
        fb[acc] = stim[acc];
        acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    check("load_state", {30'd0, state}, 1);
    check("load_core_start", {31'd0, core_start}, 1);
    check("load_in_ready_after", {31'd0, in_ready}, 0);
  endtask

  task automatic check_table();
    for (int i = 0; i < 8; i++) begin
      core_addr = tbl[i].addr;
      #1;
      check("rdata_table", {16'd0, core_rdata}, {16'd0, tbl[i].exp});
      tick();
    end
  endtask

  // mode 0: out_ready pattern 1,0,0,1; mode 1: always ready; else random.
  task automatic drain(input int mode);
    int pos = 0;
    int cyc = 0;
    while (pos < 16 && cyc < 200) begin
      case (mode)
        0:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      check("drain_out_valid", {31'd0, out_valid}, 1);
      check("drain_out_data", {24'd0, out_data}, {24'd0, exp_byte(pos)});
      if (out_ready) pos++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_end_state", {30'd0, state}, 0);
    check("drain_end_in_ready", {31'd0, in_ready}, 1);
  endtask

  initial begin
    tbl[0] = '{3'd0, 16'h0001};
    tbl[1] = '{3'd1, 16'h0203};
    tbl[2] = '{3'd2, 16'h0405};
    tbl[3] = '{3'd3, 16'h0607};
    tbl[4] = '{3'd4, 16'h0809};
    tbl[5] = '{3'd5, 16'h0A0B};
    tbl[6] = '{3'd6, 16'h0C0D};
    tbl[7] = '{3'd7, 16'h0E0F};
    for (int i = 0; i < 16; i++) fb[i] = 8'h00;

    // Reset values
    #12;
    check("rst_state", {30'd0, state}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_core_rdata", {16'd0, core_rdata}, 0);
    check("rst_core_start", {31'd0, core_start}, 0);
    rst_n = 1'b1;
    tick();

    // Load 0x00..0x0F, core_start pulse, random-access readback
    for (int i = 0; i < 16; i++) stim[i] = 8'(i);
    load_frame(0);
    tick();
    check("core_start_single", {31'd0, core_start}, 0);
    check("compute_hold", {30'd0, state}, 1);
    check_table();

    // Core writes A0+i/B0+i; done coincides with the last write
    for (int i = 0; i < 8; i++) begin
      core_we    = 1'b1;
      core_addr  = 3'(i);
      core_wdata = {8'hA0 + 8'(i), 8'hB0 + 8'(i)};
      core_done  = (i == 7);
      fb[2*i]    = 8'hA0 + 8'(i);
      fb[2*i+1]  = 8'hB0 + 8'(i);
      tick();
    end
    core_we = 1'b0;
    core_done = 1'b0;
    check("drain_entry_state", {30'd0, state}, 2);
    drain(0);

    // clr after 5 bytes; byte offered with clr must be dropped
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hF0 + 8'(i);
      tick();
    end
    clr = 1'b1;
    in_data = 8'hEE;
    #1;
    check("clr_in_ready", {31'd0, in_ready}, 0);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    check("clr_state", {30'd0, state}, 0);
    for (int i = 0; i < 16; i++) stim[i] = 8'(i);
    load_frame(0);
    check_table();

    // Reset mid-drain
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("drain2_state", {30'd0, state}, 2);
    out_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      check("drain2_out_data", {24'd0, out_data}, {24'd0, exp_byte(p)});
      tick();
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_state", {30'd0, state}, 0);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    for (int i = 0; i < 8; i++) begin
      core_addr = 3'(i);
      tick();
      check("midrst_rdata", {16'd0, core_rdata}, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) fb[i] = 8'h00;
    tick();

    // Randomized frames with gaps, random core writes, random backpressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) stim[i] = 8'($urandom);
      load_frame(1);
      for (int c = 0; c < 12; c++) begin
        in_valid   = 1'($urandom_range(0, 1));
        in_data    = 8'($urandom);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = 3'($urandom_range(0, 7));
        core_wdata = 16'($urandom);
        core_done  = (c == 11);
        if (core_we) begin
          fb[2*core_addr]   = core_wdata[15:8];
          fb[2*core_addr+1] = core_wdata[7:0];
        end
        tick();
      end
      in_valid = 1'b0;
      core_we = 1'b0;
      core_done = 1'b0;
      check("rand_drain_entry", {30'd0, state}, 2);
      drain(r == 0 ? 1 : 2);
    end

    // N=4, W=16: 4 bytes per sample, 16 bytes per frame
    core_addr16 = 2'd0;
    for (int i = 0; i < 16; i++) begin
      in_valid16 = 1'b1;
      in_data16  = (i < 4) ? 8'h12 + 8'(i) * 8'h22 : 8'(i);
      tick();
      if (i == 3) check("w16_rdata0", core_rdata16, 32'h12345678);
      if (i == 14) check("w16_not_done", {30'd0, state16}, 0);
    end
    in_valid16 = 1'b0;
    check("w16_done", {30'd0, state16}, 1);
    check("w16_core_start", {31'd0, core_start16}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
